// File: rtl/shadow_chain_serializer_pkg.sv
// ---------------------------------------------------------------------------
// shadow_capture_pkg
// Shared types and helpers for the shadow-chain serializer and for
// chain_interpreter_tm, which consumes its chains.
//   state_t        : serializer FSM states (IDLE, SHIFT)
//   frame_len()    : cycles per frame for a given chain depth
//   chain_bit_idx(): flat snapshot index of chain c, bit k
// Optional feature macro: SHADOW_PARITY_EN (one even-parity bit per chain,
// appended after the data bits).
// ---------------------------------------------------------------------------
package shadow_capture_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Serial cycles needed to emit one frame of the given chain depth.
  function automatic int frame_len(input int depth);
`ifdef SHADOW_PARITY_EN
    return depth + 1;
`else
    return depth;
`endif
  endfunction

  // Chain c bit k lives at snap[c*depth + k]; the interpreter uses the same map.
  function automatic int chain_bit_idx(input int c, input int k, input int depth);
    return c * depth + k;
  endfunction

endpackage

// File: rtl/shadow_chain_serializer_if.sv
// ---------------------------------------------------------------------------
// shadow_chain_serializer_if
// Capture/serial bus of the shadow-chain serializer.
//   capture      : snapshot strobe (master -> slave)
//   snap_in      : flat shadow state, CHAINS_IN*CHAIN_DEPTH bits (master -> slave)
//   overrun_clr  : clears the sticky overrun flag (master -> slave)
//   cout         : one serial bit per chain (slave -> master)
//   cvalid       : cout carries frame data (slave -> master)
//   frame_start  : marks bit 0 of a frame (slave -> master)
//   busy         : frame active or snapshot pending (slave -> master)
//   overrun      : sticky, a capture was dropped (slave -> master)
// ---------------------------------------------------------------------------
interface shadow_chain_serializer_if #(
  parameter int CHAINS_IN   = 3,
  parameter int CHAIN_DEPTH = 4
);
  logic                             capture;
  logic [CHAINS_IN*CHAIN_DEPTH-1:0] snap_in;
  logic                             overrun_clr;
  logic [CHAINS_IN-1:0]             cout;
  logic                             cvalid;
  logic                             frame_start;
  logic                             busy;
  logic                             overrun;

  modport master (
    output capture, snap_in, overrun_clr,
    input  cout, cvalid, frame_start, busy, overrun
  );

  modport slave (
    input  capture, snap_in, overrun_clr,
    output cout, cvalid, frame_start, busy, overrun
  );
endinterface

// File: rtl/shadow_chain_serializer_lane.sv
// ---------------------------------------------------------------------------
// shadow_chain_lane
// One serial chain: active and pending shadow bits of the chain, plus the
// bit-select mux. bit_next is the bit that will be on cout after the coming
// clock edge, so the top level can register it directly.
// Optional feature macro: SHADOW_PARITY_EN (bit CHAIN_DEPTH is even parity).
//   clk, rst     : clock, asynchronous active-low reset
//   load_active  : snap -> active this edge
//   promote      : pending -> active this edge
//   load_pend    : snap -> pending this edge
//   snap         : this chain's slice of the snapshot
//   k_next       : bit index that will be shown after this edge
//   bit_next     : selected bit for that index
// ---------------------------------------------------------------------------
module shadow_chain_lane #(
  parameter int CHAIN_DEPTH = 4,
  parameter int KW          = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_active,
  input  logic                   promote,
  input  logic                   load_pend,
  input  logic [CHAIN_DEPTH-1:0] snap,
  input  logic [KW-1:0]          k_next,
  output logic                   bit_next
);

  logic [CHAIN_DEPTH-1:0] active_reg;
  logic [CHAIN_DEPTH-1:0] active_next;
  logic [CHAIN_DEPTH-1:0] pend_reg;

  // The pending value is promoted before it is overwritten, so a promote and
  // a new pending load may share one edge.
  always_comb begin
    active_next = active_reg;
    if (load_active) begin
      active_next = snap;
    end else if (promote) begin
      active_next = pend_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_reg <= '0;
      pend_reg   <= '0;
    end else begin
      active_reg <= active_next;
      if (load_pend) begin
        pend_reg <= snap;
      end
    end
  end

  always_comb begin
    bit_next = 1'b0;
    for (int i = 0; i < CHAIN_DEPTH; i++) begin
      if (k_next == KW'(i)) begin
        bit_next = active_next[i];
      end
    end
`ifdef SHADOW_PARITY_EN
    if (k_next == KW'(CHAIN_DEPTH)) begin
      bit_next = ^active_next;
    end
`endif
  end

endmodule

// File: rtl/shadow_chain_serializer.sv
// ---------------------------------------------------------------------------
// shadow_chain_serializer
// Snapshots a flat shadow-state vector on capture and shifts it out LSB first
// as CHAINS_IN parallel chains, one bit per chain per cycle. A one-deep
// pending buffer queues a second capture behind the running frame; further
// captures are dropped and flag overrun.
// Optional feature macro: SHADOW_PARITY_EN (frame gains one even-parity bit).
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : shadow_chain_serializer_if.slave (capture, snap_in, overrun_clr in;
//          cout, cvalid, frame_start, busy, overrun out; all outputs registered)
// ---------------------------------------------------------------------------
module shadow_chain_serializer
  import shadow_capture_pkg::*;
#(
  parameter int CHAINS_IN   = 3,
  parameter int CHAIN_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  shadow_chain_serializer_if.slave  bus
);

  localparam int FRAME_LEN = frame_len(CHAIN_DEPTH);
  localparam int KW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_t               state_reg, state_next;
  logic [KW-1:0]        k_reg, k_next;
  logic                 pend_full_reg, pend_full_next;
  logic                 load_active, promote, load_pend, drop;
  logic                 last_bit;
  logic [CHAINS_IN-1:0] lane_bits;

  logic [CHAINS_IN-1:0] cout_reg, cout_next;
  logic                 cvalid_reg, cvalid_next;
  logic                 frame_start_reg, frame_start_next;
  logic                 busy_reg, busy_next;
  logic                 overrun_reg, overrun_next;

  assign last_bit = (k_reg == KW'(FRAME_LEN - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      k_reg         <= '0;
      pend_full_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      k_reg         <= k_next;
      pend_full_reg <= pend_full_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    k_next      = k_reg;
    load_active = 1'b0;
    promote     = 1'b0;
    load_pend   = 1'b0;
    drop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.capture) begin
          load_active = 1'b1;
          k_next      = '0;
          state_next  = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          k_next = '0;
          if (pend_full_reg) begin
            promote = 1'b1;
          end else if (bus.capture) begin
            // Empty buffer and a capture on the last bit: start the new frame
            // directly rather than parking it in pending, which would leave
            // pending occupied while IDLE.
            load_active = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          k_next = k_reg + 1'b1;
        end
        if (bus.capture && !load_active) begin
          if (!pend_full_reg || promote) begin
            load_pend = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    pend_full_next = load_pend | (pend_full_reg & ~promote);
  end

  // Output logic (next values of the registered outputs)
  always_comb begin
    cvalid_next      = (state_next == SHIFT);
    frame_start_next = cvalid_next && (k_next == '0);
    busy_next        = cvalid_next | pend_full_next;
    cout_next        = cvalid_next ? lane_bits : '0;
    overrun_next     = overrun_reg;
    if (drop) begin
      overrun_next = 1'b1;
    end else if (bus.overrun_clr) begin
      overrun_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cout_reg        <= '0;
      cvalid_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
    end else begin
      cout_reg        <= cout_next;
      cvalid_reg      <= cvalid_next;
      frame_start_reg <= frame_start_next;
      busy_reg        <= busy_next;
      overrun_reg     <= overrun_next;
    end
  end

  generate
    for (genvar gi = 0; gi < CHAINS_IN; gi++) begin : g_lane
      shadow_chain_lane #(
        .CHAIN_DEPTH (CHAIN_DEPTH),
        .KW          (KW)
      ) u_lane (
        .clk         (clk),
        .rst         (rst),
        .load_active (load_active),
        .promote     (promote),
        .load_pend   (load_pend),
        .snap        (bus.snap_in[chain_bit_idx(gi, 0, CHAIN_DEPTH) +: CHAIN_DEPTH]),
        .k_next      (k_next),
        .bit_next    (lane_bits[gi])
      );
    end
  endgenerate

  assign bus.cout        = cout_reg;
  assign bus.cvalid      = cvalid_reg;
  assign bus.frame_start = frame_start_reg;
  assign bus.busy        = busy_reg;
  assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_shadow_chain_serializer.sv
// ---------------------------------------------------------------------------
// tb_shadow_chain_serializer
// Directed bench for shadow_chain_serializer (CHAINS_IN=3, CHAIN_DEPTH=4).
// Honours SHADOW_PARITY_EN for the extra parity cycle of each frame.
// ---------------------------------------------------------------------------
module tb_shadow_chain_serializer;

`ifdef SHADOW_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  shadow_chain_serializer_if #(.CHAINS_IN(3), .CHAIN_DEPTH(4)) bus ();

  shadow_chain_serializer #(.CHAINS_IN(3), .CHAIN_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock, then check the serial outputs of the new cycle.
  task automatic step_check(input string tag, input logic [2:0] ec, input logic ev, input logic efs);
    @(posedge clk);
    #1;
    $display("step %s: cout=%b cvalid=%b fs=%b busy=%b overrun=%b",
             tag, bus.cout, bus.cvalid, bus.frame_start, bus.busy, bus.overrun);
    chk({tag, ".cout"},   {13'd0, bus.cout},        {13'd0, ec});
    chk({tag, ".cvalid"}, {15'd0, bus.cvalid},      {15'd0, ev});
    chk({tag, ".fs"},     {15'd0, bus.frame_start}, {15'd0, efs});
  endtask

  task automatic step_only();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    rst         = 1'b0;
    bus.capture = 1'b0;
    bus.snap_in = 12'h000;
    bus.overrun_clr = 1'b0;

    // ---- reset state
    #3;
    chk("rst.cout",    {13'd0, bus.cout}, 16'd0);
    chk("rst.cvalid",  {15'd0, bus.cvalid}, 16'd0);
    chk("rst.busy",    {15'd0, bus.busy}, 16'd0);
    chk("rst.overrun", {15'd0, bus.overrun}, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    step_check("idle0", 3'b000, 1'b0, 1'b0);

    // ---- single frame of 12'hCE5
    bus.capture = 1'b1;
    bus.snap_in = 12'hCE5;
    step_check("t1.b0", 3'b001, 1'b1, 1'b1);
    chk("t1.busy", {15'd0, bus.busy}, 16'd1);
    bus.capture = 1'b0;
    bus.snap_in = 12'h000;
    step_check("t1.b1", 3'b010, 1'b1, 1'b0);
    step_check("t1.b2", 3'b111, 1'b1, 1'b0);
    step_check("t1.b3", 3'b110, 1'b1, 1'b0);
`ifdef SHADOW_PARITY_EN
    step_check("t1.par", 3'b010, 1'b1, 1'b0);
`endif
    step_check("t1.idle", 3'b000, 1'b0, 1'b0);
    chk("t1.busy_idle", {15'd0, bus.busy}, 16'd0);

    // ---- back-to-back: CE5 then 000 queued two cycles later
    bus.capture = 1'b1;
    bus.snap_in = 12'hCE5;
    step_check("t2.b0", 3'b001, 1'b1, 1'b1);
    bus.capture = 1'b0;
    step_check("t2.b1", 3'b010, 1'b1, 1'b0);
    bus.capture = 1'b1;
    bus.snap_in = 12'h000;
    step_check("t2.b2", 3'b111, 1'b1, 1'b0);
    bus.capture = 1'b0;
    bus.snap_in = 12'hFFF;   // must not be sampled now
    step_check("t2.b3", 3'b110, 1'b1, 1'b0);
`ifdef SHADOW_PARITY_EN
    step_check("t2.par", 3'b010, 1'b1, 1'b0);
`endif
    step_check("t2.q0", 3'b000, 1'b1, 1'b1);
    for (int i = 1; i < FL; i++) step_check("t2.qn", 3'b000, 1'b1, 1'b0);
    step_check("t2.idle", 3'b000, 1'b0, 1'b0);
    chk("t2.overrun", {15'd0, bus.overrun}, 16'd0);

    // ---- A, B queued, C dropped
    bus.capture = 1'b1;
    bus.snap_in = 12'h00F;  // A: chain0 = 1111
    step_check("t3.a0", 3'b001, 1'b1, 1'b1);
    bus.snap_in = 12'hF00;  // B: chain2 = 1111
    step_check("t3.a1", 3'b001, 1'b1, 1'b0);
    bus.snap_in = 12'h0F0;  // C: chain1 = 1111, dropped
    step_check("t3.a2", 3'b001, 1'b1, 1'b0);
    chk("t3.overrun", {15'd0, bus.overrun}, 16'd1);
    bus.capture = 1'b0;
    step_check("t3.a3", 3'b001, 1'b1, 1'b0);
`ifdef SHADOW_PARITY_EN
    step_check("t3.apar", 3'b000, 1'b1, 1'b0);
`endif
    step_check("t3.b0", 3'b100, 1'b1, 1'b1);
    for (int i = 1; i < 4; i++) step_check("t3.bn", 3'b100, 1'b1, 1'b0);
`ifdef SHADOW_PARITY_EN
    step_check("t3.bpar", 3'b000, 1'b1, 1'b0);
`endif
    step_check("t3.idle", 3'b000, 1'b0, 1'b0);
    chk("t3.busy_idle", {15'd0, bus.busy}, 16'd0);

    // ---- overrun clear, then drop and clear in the same cycle
    bus.overrun_clr = 1'b1;
    step_only();
    bus.overrun_clr = 1'b0;
    chk("t4.clr0", {15'd0, bus.overrun}, 16'd0);
    bus.capture = 1'b1;
    bus.snap_in = 12'h00F;
    step_only();             // A starts
    step_only();             // B queued
    bus.overrun_clr = 1'b1;  // C dropped, same cycle as clear
    step_only();
    chk("t4.setwins", {15'd0, bus.overrun}, 16'd1);
    bus.capture = 1'b0;
    step_only();             // clear alone
    bus.overrun_clr = 1'b0;
    chk("t4.clr1", {15'd0, bus.overrun}, 16'd0);
    repeat (2 * FL) step_only();
    chk("t4.drain_cvalid", {15'd0, bus.cvalid}, 16'd0);
    chk("t4.drain_busy",   {15'd0, bus.busy}, 16'd0);

    // ---- async reset mid-frame with a pending capture and a set overrun
    bus.capture = 1'b1;
    bus.snap_in = 12'hCE5;
    step_check("t5.b0", 3'b001, 1'b1, 1'b1);
    bus.snap_in = 12'hFFF;
    step_check("t5.b1", 3'b010, 1'b1, 1'b0);
    step_check("t5.b2", 3'b111, 1'b1, 1'b0);
    bus.capture = 1'b0;
    chk("t5.pre_overrun", {15'd0, bus.overrun}, 16'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t5.cout",    {13'd0, bus.cout}, 16'd0);
    chk("t5.cvalid",  {15'd0, bus.cvalid}, 16'd0);
    chk("t5.fs",      {15'd0, bus.frame_start}, 16'd0);
    chk("t5.busy",    {15'd0, bus.busy}, 16'd0);
    chk("t5.overrun", {15'd0, bus.overrun}, 16'd0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 2 * FL; i++) begin
      step_check("t5.quiet", 3'b000, 1'b0, 1'b0);
      chk("t5.quiet_busy", {15'd0, bus.busy}, 16'd0);
    end
    bus.capture = 1'b1;
    bus.snap_in = 12'hCE5;
    step_check("t5.new0", 3'b001, 1'b1, 1'b1);
    bus.capture = 1'b0;
    step_check("t5.new1", 3'b010, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
